// File: rtl/img_uart_tx_pkg.sv
// Shared definitions for the image-RAM readback UART transmitter:
// FSM state encoding and the baud divisor calculation.
package img_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } state_t;

  // Clock cycles per serial bit, truncated.
  function automatic int baud_divisor(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_bitclk.sv
// Baud counter: counts 0..Divisor-1 and pulses bit_tick on the last count.
// clear restarts the count so the first bit of a frame is full length.
module uart_tx_bitclk #(
  parameter int Divisor = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(Divisor - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       cnt <= '0;
    else if (clear || cnt == LastCnt) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  assign bit_tick = (cnt == LastCnt) && !clear;

endmodule

// File: rtl/img_uart_tx.sv
// Reads the image buffer from address 0 to ImgWords-1 and sends each word
// as an 8N1-style UART frame, LSB first, on tx.
module img_uart_tx
  import img_uart_tx_pkg::*;
#(
  parameter int AddressWidth = 14,
  parameter int DataWidth    = 8,
  parameter int ImgWords     = 2**AddressWidth,
  parameter int ClkFreq      = 12000000,
  parameter int BaudRate     = 115200
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    ram_rw,
  output logic [AddressWidth-1:0] ram_addr,
  input  logic [DataWidth-1:0]    ram_data,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int Divisor = baud_divisor(ClkFreq, BaudRate);
  localparam int BW      = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [BW-1:0]         LastBit  = BW'(DataWidth - 1);
  // One extra bit so a full 2**AddressWidth dump ends without wrapping.
  localparam logic [AddressWidth:0] LastWord = (AddressWidth + 1)'(ImgWords - 1);

  state_t                 state, state_nx;
  logic [AddressWidth:0]  wcnt;
  logic [DataWidth-1:0]   shift;
  logic [BW-1:0]          bidx;
  logic                   tx_q;
  logic                   bit_tick;

  uart_tx_bitclk #(.Divisor(Divisor)) u_bitclk (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (state == ST_LATCH),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_FETCH;
      end
      ST_FETCH: state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_START;
      ST_START: if (bit_tick) state_nx = ST_DATA;
      ST_DATA:  if (bit_tick && bidx == LastBit) state_nx = ST_STOP;
      ST_STOP:  if (bit_tick) state_nx = (wcnt == LastWord) ? ST_DONE : ST_FETCH;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt  <= '0;
      shift <= '0;
      bidx  <= '0;
    end else begin
      if (state == ST_IDLE && start)
        wcnt <= '0;
      else if (state == ST_STOP && bit_tick && wcnt != LastWord)
        wcnt <= wcnt + 1'b1;

      if (state == ST_LATCH)
        shift <= ram_data;
      else if (state == ST_DATA && bit_tick)
        shift <= shift >> 1;

      if (state == ST_START)
        bidx <= '0;
      else if (state == ST_DATA && bit_tick)
        bidx <= bidx + 1'b1;
    end
  end

  // Registered line driver keeps tx glitch-free; it trails the state by one clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_q <= 1'b1;
    else begin
      case (state)
        ST_START: tx_q <= 1'b0;
        ST_DATA:  tx_q <= shift[0];
        default:  tx_q <= 1'b1;
      endcase
    end
  end

  assign tx       = tx_q;
  assign ram_rw   = 1'b1;
  assign ram_addr = wcnt[AddressWidth-1:0];

endmodule

// File: tb/tb_img_uart_tx.sv
// Directed bench for img_uart_tx: registered-read RAM model, UART monitor on tx,
// table of RAM words with expected decoded bytes and leading-low run lengths.
module tb_img_uart_tx;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int IW = 16;
  localparam int FRAME = 102;
  localparam int DONE_CYC = 1 + IW * FRAME;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          tx, busy, done;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rw) ram_data <= mem[ram_addr];

  img_uart_tx #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .ImgWords     (IW),
    .ClkFreq      (1000000),
    .BaudRate     (100000)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // UART monitor: first low sample is start-bit cycle 0, data sampled mid-bit.
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int   mon_byte[$], mon_t0[$], mon_low[$], mon_stop[$];
  int   done_cnt = 0;
  bit   mf = 0, lact = 0;
  int   mpos = 0, lrun = 0, t0 = 0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    if (!rstn) mf = 0;
    else if (!mf) begin
      if (tx == 1'b0) begin
        mf = 1; mpos = 0; lrun = 1; lact = 1; t0 = cyc;
      end
    end else begin
      mpos++;
      if (lact && tx == 1'b0) lrun++;
      else lact = 0;
      if (mpos >= 15 && mpos <= 85 && (mpos % 10) == 5) sh[3'((mpos - 15) / 10)] = tx;
      if (mpos == 95) begin
        mon_byte.push_back(int'(sh));
        mon_t0.push_back(t0);
        mon_low.push_back(lrun);
        mon_stop.push_back(int'(tx));
        mf = 0;
      end
    end
  end

  always @(negedge clk) if (rstn && done) done_cnt++;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_byte;
    int         exp_low;   // start bit plus trailing zero data bits, in cycles
  } vec_t;

  vec_t tbl_seq  [16];
  vec_t tbl_edge [16];

  task automatic load_mem(input vec_t t [16]);
    for (int i = 0; i < 16; i++) mem[i] = t[i].data;
  endtask

  // kill_at > 0 asserts reset at that cycle of the dump instead of finishing it.
  task automatic do_dump(input vec_t t [16], input bit busy_starts,
                         input bit done_start, input int kill_at);
    int nb, dc0, c, c_done, q;
    bit seen, killed;
    nb = mon_byte.size(); dc0 = done_cnt; c = 0; c_done = -1; seen = 0; killed = 0;
    @(negedge clk);
    start = 1'b1;
    while (!seen && !killed && c < 4000) begin
      @(negedge clk);
      c++;
      start = busy_starts && (c == 50 || c == 500);
      if (c == 1) begin
        chk("fetch_busy", busy, 1);
        chk("fetch_addr", ram_addr, 0);
      end
      if (c == 3) chk("latch_tx_high", tx, 1);
      if (c == 4) chk("start_bit_low", tx, 0);
      if (kill_at > 0 && c == kill_at) begin
        rstn = 1'b0;
        #1;
        chk("kill_tx", tx, 1);
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        killed = 1;
      end else if (done) begin
        seen = 1;
        c_done = c;
        chk("done_busy", busy, 1);
        if (done_start) start = 1'b1;
      end
    end
    if (killed) begin
      repeat (3) @(negedge clk);
      chk("kill_addr", ram_addr, 0);
      rstn = 1'b1;
      q = 0;
      repeat (300) begin
        @(negedge clk);
        if (busy || !tx || done) q++;
      end
      chk("kill_quiet", q, 0);
      chk("kill_no_done", done_cnt - dc0, 0);
    end else begin
      if (!seen) chk("done_timeout", 0, 1);
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", busy, 0);
      q = 0;
      repeat (30) begin
        @(negedge clk);
        if (busy || !tx) q++;
      end
      chk("no_restart", q, 0);
      chk("done_count", done_cnt - dc0, 1);
      chk("done_cycle", c_done, DONE_CYC);
      chk("byte_count", mon_byte.size() - nb, 16);
      for (int i = 0; i < 16; i++) begin
        if (nb + i < mon_byte.size()) begin
          chk($sformatf("byte%0d", i), mon_byte[nb + i], int'(t[i].exp_byte));
          chk($sformatf("lowrun%0d", i), mon_low[nb + i], t[i].exp_low);
          chk($sformatf("stop%0d", i), mon_stop[nb + i], 1);
          if (i > 0) chk($sformatf("period%0d", i), mon_t0[nb + i] - mon_t0[nb + i - 1], FRAME);
        end
      end
    end
  endtask

  initial begin
    int edges;
    logic prev;

    tbl_seq = '{
      '{8'h00, 8'h00, 90}, '{8'h01, 8'h01, 10}, '{8'h02, 8'h02, 20}, '{8'h03, 8'h03, 10},
      '{8'h04, 8'h04, 30}, '{8'h05, 8'h05, 10}, '{8'h06, 8'h06, 20}, '{8'h07, 8'h07, 10},
      '{8'h08, 8'h08, 40}, '{8'h09, 8'h09, 10}, '{8'h0A, 8'h0A, 20}, '{8'h0B, 8'h0B, 10},
      '{8'h0C, 8'h0C, 30}, '{8'h0D, 8'h0D, 10}, '{8'h0E, 8'h0E, 20}, '{8'h0F, 8'h0F, 10}
    };
    tbl_edge = tbl_seq;
    tbl_edge[0] = '{8'hA5, 8'hA5, 10};
    tbl_edge[1] = '{8'hFF, 8'hFF, 10};

    load_mem(tbl_seq);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rw", ram_rw, 1);
    chk("rst_addr", ram_addr, 0);
    rstn = 1'b1;
    edges = 0;
    prev = tx;
    repeat (200) begin
      @(negedge clk);
      if (tx !== prev) edges++;
      prev = tx;
    end
    chk("idle_no_tx_edge", edges, 0);
    chk("idle_rw", ram_rw, 1);

    // Plain dump of 0x00..0x0F
    do_dump(tbl_seq, 0, 0, 0);

    // Edge data: 0xA5 and 0xFF in the first two words
    load_mem(tbl_edge);
    do_dump(tbl_edge, 0, 0, 0);
    load_mem(tbl_seq);

    // Start pulses while busy and in the DONE cycle are ignored
    do_dump(tbl_seq, 1, 1, 0);

    // Reset during DATA bit 3 of word 5, then a fresh dump from address 0
    do_dump(tbl_seq, 0, 0, 1 + 5 * FRAME + 47);
    do_dump(tbl_seq, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_uart_tx.md
# img_uart_tx

Image-RAM readback transmitter for the VGA image receiver design. On a start pulse it reads the image buffer sequentially from address 0 to the last word through the buffer's read port. It serialises each word as an 8N1-style UART frame (LSB first) on a single TX line. This lets the host verify or dump the frame that the receiver path wrote into the RAM.

## Interface
- AddressWidth, 14, image RAM address width; must match the image buffer
- DataWidth, 8, RAM word width; one UART frame carries DataWidth data bits
- ImgWords, 2**AddressWidth, number of words sent per dump (1..2**AddressWidth)
- ClkFreq, 12000000, clk frequency in Hz
- BaudRate, 115200, serial bit rate

- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a dump; ignored while busy
- ram_rw  out  1  RAM read/write select; held at 1 (read) at all times, including reset
- ram_addr  out  AddressWidth  RAM read address
- ram_data  in  DataWidth  RAM read data, valid one clk after ram_addr is presented with ram_rw=1
- tx  out  1  serial output, idle high
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
- done  out  1  one-cycle pulse after the stop bit of the last word

## Operation
- Divisor = ClkFreq/BaudRate, integer truncated; default 104. A baud counter counts 0..Divisor-1 and restarts on every bit boundary.
- States:
  - IDLE: tx=1, busy=0. On start=1: word counter=0, go to FETCH.
  - FETCH: drive ram_addr=word counter. Next cycle go to LATCH.
  - LATCH: capture ram_data into the shift register. Go to START.
  - START: tx=0 for Divisor cycles. Go to DATA with bit index 0.
  - DATA: tx=shift[0] for Divisor cycles, then shift right. After DataWidth bits go to STOP.
  - STOP: tx=1 for Divisor cycles. Then:
    - if word counter=ImgWords-1, go to DONE;
    - otherwise increment the counter and go to FETCH.
  - DONE: done=1 for one cycle, busy=1. Go to IDLE.
- Word counter is AddressWidth+1 bits wide so ImgWords=2**AddressWidth terminates without wrap. ram_addr takes the low AddressWidth bits.
- start asserted in any state other than IDLE has no effect and is not queued. start asserted in the DONE cycle is also ignored.
- RAM contents are never modified; ram_rw is constant 1.

## Timing
- Reset values: tx=1, busy=0, done=0, ram_addr=0, ram_rw=1. The FSM returns to IDLE and the counters clear.
- Reset mid-frame: tx returns high immediately. The partial frame is abandoned and no done pulse is produced.
- start sampled high at edge N:
  - FETCH in cycle N+1, with ram_addr valid and busy=1.
  - LATCH in cycle N+2.
  - tx falls at edge N+3.
- Each word occupies 2 + (DataWidth+2)·Divisor cycles. For the defaults this is 2 + 10·104 = 1042 cycles.
- Full dump: 1 + ImgWords·(2 + (DataWidth+2)·Divisor) cycles from start to the done cycle, inclusive of DONE.
- Gap between consecutive frames: tx stays high for the STOP period plus 2 cycles (FETCH and LATCH).

## Structure
- Shared package holds:
  - the state encoding (IDLE, FETCH, LATCH, START, DATA, STOP, DONE);
  - a function computing Divisor from ClkFreq and BaudRate.
- One natural sub-module, uart_tx_bitclk: the baud counter, emitting a one-cycle bit_tick and cleared on frame start. The FSM, shift register and address counter stay in img_uart_tx.

## Test plan
- Bench parameters: ClkFreq=1000000, BaudRate=100000 (Divisor=10), AddressWidth=4. The RAM model has registered read and is preloaded with 0x00..0x0F.
- Reset: hold rstn=0, then release.
  - Required: tx=1, busy=0, done=0, ram_rw=1.
  - No tx edge for 200 cycles without start.
- Single dump, ImgWords=16, with a UART monitor on tx.
  - Decodes bytes 0x00..0x0F in order.
  - Each start bit lasts 10 cycles; each frame lasts 102 cycles.
  - done pulses exactly once, at cycle 1 + 16·102 = 1633 after start.
- Edge data: RAM words 0xA5 and 0xFF.
  - Decoded bit sequence is LSB first: 1,0,1,0,0,1,0,1.
  - For 0xFF, tx stays high from the first data bit through the stop bit.
- Start during busy: pulse start at the 50th and 500th cycles of a dump.
  - Byte count is still 16 and done pulses once.
  - A start pulse in the DONE cycle is ignored: busy falls with no new dump.
- Reset mid-frame: assert rstn=0 during the DATA bit 3 of word 5.
  - tx=1 and busy=0 immediately; no done pulse.
  - A subsequent start restarts the dump at ram_addr=0.
